// File: rtl/expr_gen.sv
// Token buffer that collects a digit/operator expression and streams it out
// as ASCII characters under a valid/ready handshake.
module expr_gen #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     tok_we,
  input  logic                     tok_op,
  input  logic [3:0]               tok_val,
  input  logic                     send,
  input  logic                     ready,
  output logic [7:0]               out_char,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     full,
  output logic                     err,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    LOAD,
    SEND,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      buf_q [DEPTH];
  logic [7:0]      buf_d [DEPTH];
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            last_op_q, last_op_d;
  logic            err_q, err_d;

  logic [7:0]      tok_char;
  logic            is_full;
  logic            is_empty;
  logic            wr_ok;
  logic            send_ok;
  logic            last_char;

  // Tokens are stored already translated to ASCII so emission is a plain read.
  always_comb begin
    tok_char  = tok_op ? (tok_val[0] ? 8'h2A : 8'h2B) : (8'h30 + {4'h0, tok_val});
    is_full   = (count_q == CW'(DEPTH));
    is_empty  = (count_q == '0);
    wr_ok     = !is_full && (tok_op ? (!is_empty && !last_op_q)
                                    : ((tok_val <= 4'd9) && (is_empty || last_op_q)));
    send_ok   = !is_empty && !last_op_q;
    last_char = (CW'(rd_ptr_q) == (count_q - CW'(1)));
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= LOAD;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      last_op_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      last_op_q <= last_op_d;
      err_q     <= err_d;
    end
  end

  // Storage needs no reset: count and pointers define which entries are live.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD: if (send && !tok_we && send_ok) state_d = SEND;
      SEND: if (ready && last_char)         state_d = DONE;
      DONE:                                 state_d = LOAD;
      default:                              state_d = LOAD;
    endcase
  end

  always_comb begin
    buf_d     = buf_q;
    count_d   = count_q;
    rd_ptr_d  = rd_ptr_q;
    last_op_d = last_op_q;
    err_d     = err_q;
    unique case (state_q)
      LOAD: begin
        // A write in the same cycle as send takes precedence; send is dropped.
        if (tok_we) begin
          if (wr_ok) begin
            buf_d[count_q[AW-1:0]] = tok_char;
            count_d                = count_q + CW'(1);
            last_op_d              = tok_op;
          end else begin
            err_d = 1'b1;
          end
        end else if (send) begin
          if (send_ok) begin
            err_d    = 1'b0;
            rd_ptr_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (tok_we) err_d = 1'b1;
        if (ready) begin
          if (last_char) begin
            count_d   = '0;
            rd_ptr_d  = '0;
            last_op_d = 1'b0;
          end else begin
            rd_ptr_d = rd_ptr_q + AW'(1);
          end
        end
      end
      DONE: begin
        if (tok_we) err_d = 1'b1;
      end
      default: begin
        err_d = err_q;
      end
    endcase
  end

  always_comb begin
    out_valid = (state_q == SEND);
    out_char  = out_valid ? buf_q[rd_ptr_q] : 8'h00;
    busy      = (state_q != LOAD);
    done      = (state_q == DONE);
    full      = is_full;
    err       = err_q;
    count     = count_q;
  end

endmodule

// File: tb/tb_expr_gen.sv
// Directed self-checking bench for expr_gen: loading, streaming, backpressure,
// grammar errors, capacity limit and mid-stream clear.
module tb_expr_gen;

  logic       clk;
  logic       clr;
  logic       tok_we;
  logic       tok_op;
  logic [3:0] tok_val;
  logic       send;
  logic       ready;
  logic [7:0] out_char;
  logic       out_valid;
  logic       busy;
  logic       full;
  logic       err;
  logic       done;
  logic [4:0] count;

  int vectors;
  int miscompares;

  expr_gen #(.DEPTH(16)) dut (
    .clk       (clk),
    .clr       (clr),
    .tok_we    (tok_we),
    .tok_op    (tok_op),
    .tok_val   (tok_val),
    .send      (send),
    .ready     (ready),
    .out_char  (out_char),
    .out_valid (out_valid),
    .busy      (busy),
    .full      (full),
    .err       (err),
    .done      (done),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic op, input logic [3:0] val);
    tok_we  = 1'b1;
    tok_op  = op;
    tok_val = val;
    tick();
    tok_we  = 1'b0;
  endtask

  task automatic doClear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Snapshot of stream-side outputs.
  task automatic checkStream(input string tag, input logic v, input logic [7:0] c,
                             input logic b, input logic d);
    checkOutput({tag, ".valid"}, 32'(out_valid), 32'(v));
    checkOutput({tag, ".char"},  32'(out_char),  32'(c));
    checkOutput({tag, ".busy"},  32'(busy),      32'(b));
    checkOutput({tag, ".done"},  32'(done),      32'(d));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clr = 1'b1; tok_we = 1'b0; tok_op = 1'b0; tok_val = 4'd0; send = 1'b0; ready = 1'b0;
    tick();
    clr = 1'b0;

    // reset state
    checkStream("rst", 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("rst.count", 32'(count), 32'd0);
    checkOutput("rst.full",  32'(full),  32'd0);
    checkOutput("rst.err",   32'(err),   32'd0);

    // 3+4*5 streamed with ready held high
    applyStimulus(1'b0, 4'd3);
    applyStimulus(1'b1, 4'd0);
    applyStimulus(1'b0, 4'd4);
    applyStimulus(1'b1, 4'd1);
    applyStimulus(1'b0, 4'd5);
    checkOutput("a.count", 32'(count), 32'd5);
    checkOutput("a.err",   32'(err),   32'd0);
    ready = 1'b1; send = 1'b1;
    tick();
    send = 1'b0;
    checkStream("a.c0", 1'b1, 8'h33, 1'b1, 1'b0);
    checkOutput("a.c0.count", 32'(count), 32'd5);
    tick(); checkStream("a.c1", 1'b1, 8'h2B, 1'b1, 1'b0);
    tick(); checkStream("a.c2", 1'b1, 8'h34, 1'b1, 1'b0);
    tick(); checkStream("a.c3", 1'b1, 8'h2A, 1'b1, 1'b0);
    tick(); checkStream("a.c4", 1'b1, 8'h35, 1'b1, 1'b0);
    checkOutput("a.c4.count", 32'(count), 32'd5);
    tick(); checkStream("a.done", 1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("a.done.count", 32'(count), 32'd0);
    tick(); checkStream("a.idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // 9*1 with backpressure on the operator
    applyStimulus(1'b0, 4'd9);
    applyStimulus(1'b1, 4'd1);
    applyStimulus(1'b0, 4'd1);
    send = 1'b1;
    tick();
    send = 1'b0;
    checkStream("b.c0", 1'b1, 8'h39, 1'b1, 1'b0);
    tick();
    checkStream("b.c1", 1'b1, 8'h2A, 1'b1, 1'b0);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkStream("b.hold", 1'b1, 8'h2A, 1'b1, 1'b0);
    end
    ready = 1'b1;
    tick(); checkStream("b.c2", 1'b1, 8'h31, 1'b1, 1'b0);
    tick(); checkStream("b.done", 1'b0, 8'h00, 1'b1, 1'b1);
    tick(); checkStream("b.idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // grammar errors, then a good send clears err
    doClear();
    applyStimulus(1'b1, 4'd0);
    checkOutput("c.op.err",   32'(err),   32'd1);
    checkOutput("c.op.count", 32'(count), 32'd0);
    applyStimulus(1'b0, 4'd7);
    checkOutput("c.d7.count", 32'(count), 32'd1);
    applyStimulus(1'b0, 4'd8);
    checkOutput("c.d8.count", 32'(count), 32'd1);
    checkOutput("c.d8.err",   32'(err),   32'd1);
    send = 1'b1;
    tick();
    send = 1'b0;
    checkOutput("c.send.err", 32'(err), 32'd0);
    checkStream("c.c0", 1'b1, 8'h37, 1'b1, 1'b0);
    tick(); checkStream("c.done", 1'b0, 8'h00, 1'b1, 1'b1);
    tick();

    // out-of-range digit
    doClear();
    applyStimulus(1'b0, 4'd10);
    checkOutput("d.big.err",   32'(err),   32'd1);
    checkOutput("d.big.count", 32'(count), 32'd0);

    // send with trailing operator is refused
    doClear();
    applyStimulus(1'b0, 4'd2);
    applyStimulus(1'b1, 4'd0);
    send = 1'b1;
    tick();
    send = 1'b0;
    checkOutput("d.send.err",   32'(err),   32'd1);
    checkOutput("d.send.count", 32'(count), 32'd2);
    checkStream("d.send", 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("d.send2.valid", 32'(out_valid), 32'd0);

    // fill to capacity, then one more write
    doClear();
    for (int i = 0; i < 16; i++) applyStimulus(i[0], 4'(i % 10));
    checkOutput("e.count", 32'(count), 32'd16);
    checkOutput("e.full",  32'(full),  32'd1);
    checkOutput("e.err",   32'(err),   32'd0);
    applyStimulus(1'b0, 4'd5);
    checkOutput("e.17.count", 32'(count), 32'd16);
    checkOutput("e.17.err",   32'(err),   32'd1);
    checkOutput("e.17.full",  32'(full),  32'd1);

    // clear on the second character of 1+2*3
    doClear();
    applyStimulus(1'b0, 4'd1);
    applyStimulus(1'b1, 4'd0);
    applyStimulus(1'b0, 4'd2);
    applyStimulus(1'b1, 4'd1);
    applyStimulus(1'b0, 4'd3);
    ready = 1'b1; send = 1'b1;
    tick();
    send = 1'b0;
    checkStream("f.c0", 1'b1, 8'h31, 1'b1, 1'b0);
    tick();
    checkStream("f.c1", 1'b1, 8'h2B, 1'b1, 1'b0);
    doClear();
    checkStream("f.clr", 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("f.clr.count", 32'(count), 32'd0);
    checkOutput("f.clr.err",   32'(err),   32'd0);
    tick();
    checkStream("f.after", 1'b0, 8'h00, 1'b0, 1'b0);

    // write+send together, then a write during SEND
    applyStimulus(1'b0, 4'd4);
    tok_we = 1'b1; tok_op = 1'b1; tok_val = 4'd0; send = 1'b1;
    tick();
    tok_we = 1'b0; send = 1'b0;
    checkOutput("g.ws.count", 32'(count), 32'd2);
    checkOutput("g.ws.err",   32'(err),   32'd0);
    checkStream("g.ws", 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd6);
    checkOutput("g.d6.count", 32'(count), 32'd3);
    send = 1'b1;
    tick();
    send = 1'b0;
    checkStream("g.c0", 1'b1, 8'h34, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'd9);
    checkStream("g.c1", 1'b1, 8'h2B, 1'b1, 1'b0);
    checkOutput("g.we.err",   32'(err),   32'd1);
    checkOutput("g.we.count", 32'(count), 32'd3);
    tick(); checkStream("g.c2", 1'b1, 8'h36, 1'b1, 1'b0);
    tick(); checkStream("g.done", 1'b0, 8'h00, 1'b1, 1'b1);
    tick(); checkStream("g.idle", 1'b0, 8'h00, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/expr_gen.md
EXPR_GEN -- requirements
Module: expr_gen

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning token buffer capacity (entries).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port clr  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port tok_we  input  1  token write strobe.
REQ-005 SHALL have port tok_op  input  1  token kind: 0 = digit, 1 = operator.
REQ-006 SHALL have port tok_val  input  4  digit value 0-9, or for an operator bit0 = 0 for '+' and 1 for '*' (bits 3:1 ignored).
REQ-007 SHALL have port send  input  1  request to emit the buffered expression.
REQ-008 SHALL have port ready  input  1  downstream accepts out_char this cycle.
REQ-009 SHALL have port out_char  output  8  ASCII character being offered.
REQ-010 SHALL have port out_valid  output  1  out_char is valid.
REQ-011 SHALL have port busy  output  1  high in SEND and DONE.
REQ-012 SHALL have port full  output  1  count == DEPTH.
REQ-013 SHALL have port err  output  1  sticky protocol or grammar error.
REQ-014 SHALL have port done  output  1  one-cycle pulse after the last character is accepted.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  number of buffered tokens.

Function
REQ-016 SHALL implement the states LOAD, SEND and DONE, with LOAD as the reset state.
REQ-017 SHALL, in LOAD, accept a digit on tok_we only if !full, tok_val <= 9, and either the buffer is empty or the last token is an operator.
REQ-018 SHALL, in LOAD, accept an operator on tok_we only if !full and the last token is a digit.
REQ-019 SHALL, on a rejected tok_we, leave the buffer and count unchanged and set err.
REQ-020 SHALL, on tok_we in SEND or DONE, ignore the write and set err.
REQ-021 SHALL, on send in LOAD with count > 0 and a digit as last token, enter SEND next cycle, clear err, and assert out_valid with the first token (latency 1 cycle).
REQ-022 SHALL, on send in LOAD with count == 0 or an operator as last token, set err, stay in LOAD and keep out_valid low.
REQ-023 SHALL, when tok_we and send are asserted in the same LOAD cycle, process the write and ignore send (no err from send).
REQ-024 SHALL ignore send outside LOAD.
REQ-025 SHALL map a digit d to out_char 0x30+d, '+' to 0x2B and '*' to 0x2A.
REQ-026 SHALL, in SEND, hold out_valid high and out_char stable while ready is low.
REQ-027 SHALL, in SEND, advance to the next token on out_valid && ready, emitting one character per cycle when ready stays high.
REQ-028 SHALL, on acceptance of the final token, enter DONE; DONE SHALL last one cycle with done = 1, out_valid = 0 and count = 0, then return to LOAD.
REQ-029 SHALL, in SEND, keep count equal to the loaded length and leave it unchanged by emission.
REQ-030 SHALL, every emitted sequence, match digit(op digit)* exactly.
REQ-031 SHALL hold out_char at 0x00 whenever out_valid is low.

Reset
REQ-032 SHALL, on clr high at a clock edge, set state LOAD, count 0, buffer pointers 0, out_char 0x00, and out_valid, busy, full, err and done all 0, regardless of state.
REQ-033 SHALL give clr priority over tok_we, send and ready in the same cycle.
REQ-034 SHALL, on clr mid-SEND, abandon the sequence with no done pulse and out_valid low from the next cycle.

Verification
REQ-035 SHALL be verified by: load 3,'+',4,'*',5; send; ready = 1 -> out_char 0x33, 0x2B, 0x34, 0x2A, 0x35 on 5 consecutive cycles starting 1 cycle after send, done 1 cycle later, then count 0 and busy 0.
REQ-036 SHALL be verified by: load 9,'*',1; send; ready low for 3 cycles while 0x2A is offered -> out_char held at 0x2A with out_valid = 1, then 0x31 and done.
REQ-037 SHALL be verified by: after clr, write an operator -> err = 1 and count 0; then digits 7, 8 -> count 1 and err stays 1; then send -> err cleared and 0x37 emitted.
REQ-038 SHALL be verified by: load 2,'+' then send -> err = 1 and no out_valid; DEPTH = 16 alternating tokens -> full = 1, and a 17th write is rejected with err and count 16.
REQ-039 SHALL be verified by: clr on the 2nd character of a 5-token send -> next cycle out_valid 0, busy 0, count 0, no done pulse.
REQ-040 SHALL be verified by: tok_we and send in the same cycle with buffer holding 4 -> write accepted, no transition; tok_we during SEND -> ignored with err = 1 and the stream uncorrupted.
